// File: rtl/bcd_sub4_seq.sv
// bcd_sub4_seq: sequential 4-digit packed-BCD subtractor producing |A-B|.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request a subtraction (sampled only while idle)
//   A, B     minuend / subtrahend, 4 packed BCD digits, [3:0] least significant
//   D        magnitude |A-B| as 4 packed BCD digits
//   neg      1 when A<B
//   invalid  1 when any digit of A or B exceeds 9
//   busy     high while digits are being processed
//   done     one-cycle pulse; D/neg/invalid are valid from here until the next start
//
// One digit is handled per cycle. A negative ten's-complement result gets a
// second four-cycle pass (0 - r) to recover the magnitude.
module bcd_sub4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] D,
  output logic        neg,
  output logic        invalid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    NEGATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] a_r, b_r;   // latched operands
  logic [15:0] r;          // working result register
  logic [1:0]  idx;        // current digit index
  logic        borrow;

  logic [3:0]  op_a, op_b;
  logic [4:0]  t;
  logic [3:0]  dig;
  logic        bout;
  logic [15:0] r_nxt;
  logic        bad_in;

  function automatic logic has_bad_digit(input logic [15:0] x);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in = has_bad_digit(A) | has_bad_digit(B);

  // Digit operands: in NEGATE the minuend is zero and the subtrahend is the
  // ten's-complement result digit being converted.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == NEGATE) begin
      op_a = '0;
      op_b = r[{idx, 2'b00} +: 4];
    end else begin
      op_a = a_r[{idx, 2'b00} +: 4];
      op_b = b_r[{idx, 2'b00} +: 4];
    end
  end

  // t is biased by +10 so it never goes below zero: t>=10 means no borrow.
  always_comb begin
    t    = {1'b0, op_a} + 5'd10 - {1'b0, op_b} - {4'b0000, borrow};
    dig  = '0;
    bout = 1'b0;
    if (t >= 5'd10) begin
      dig  = 4'(t - 5'd10);
      bout = 1'b0;
    end else begin
      dig  = t[3:0];
      bout = 1'b1;
    end
    r_nxt = r;
    r_nxt[{idx, 2'b00} +: 4] = dig;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = bad_in ? DONE : SUB;
      end
      SUB: begin
        if (idx == 2'd3) state_nxt = bout ? NEGATE : DONE;
      end
      NEGATE: begin
        if (idx == 2'd3) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SUB, NEGATE: busy = 1'b1;
      DONE:        done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operands, working result, index/borrow and the held outputs.
  // D is written only on the transition into DONE so it stays stable while
  // the next operation is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      r       <= '0;
      idx     <= '0;
      borrow  <= 1'b0;
      D       <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            r       <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            neg     <= 1'b0;
            invalid <= bad_in;
            if (bad_in) D <= '0;
          end
        end
        SUB: begin
          r      <= r_nxt;
          idx    <= idx + 2'd1;
          borrow <= bout;
          if (idx == 2'd3) begin
            if (bout) begin
              neg    <= 1'b1;
              borrow <= 1'b0;   // fresh borrow chain for the negate pass
            end else begin
              D <= r_nxt;
            end
          end
        end
        NEGATE: begin
          r      <= r_nxt;
          idx    <= idx + 2'd1;
          borrow <= bout;
          if (idx == 2'd3) D <= r_nxt;
        end
        DONE: begin
          idx    <= '0;
          borrow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
